// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment driver.
// Scans DIGITS digits from left (DIGITS-1) to right (0). Each slot has an
// optional one-cycle all-off gap followed by DWELL lit cycles. Inputs are
// snapshotted once per frame. Segments and anodes are active-low, and both
// are registered.

// Per-digit pattern select: blank, then blink-off, then raw, then hex decode.
module seg_scan_digit (
    input  logic [3:0] nib_i,
    input  logic [6:0] raw_i,
    input  logic       raw_en_i,
    input  logic       blank_i,
    input  logic       blink_i,
    input  logic       blink_phase_i,
    output logic [6:0] pat_o
);
    logic [6:0] hex;

    // Hex to active-low segment decode (bit6=g .. bit0=a)
    always_comb begin
        hex = 7'h7F;
        case (nib_i)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

    // Priority: forced dark, then blink-off half period, then raw, then hex
    always_comb begin
        pat_o = hex;
        if (blank_i)
            pat_o = 7'h7F;
        else if (blink_i && blink_phase_i)
            pat_o = 7'h7F;
        else if (raw_en_i)
            pat_o = raw_i;
    end
endmodule

module seg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int DWELL        = 1,
    parameter int GHOST        = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  segclk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_val,
    input  logic [7*DIGITS-1:0]   raw_seg,
    input  logic [DIGITS-1:0]     raw_en,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {S_GAP = 1'b0, S_DRIVE = 1'b1} state_t;
    // Each slot opens with a gap when ghost suppression is on, otherwise
    // with a lit cycle.
    localparam state_t S_FIRST = (GHOST != 0) ? S_GAP : S_DRIVE;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic                 blink_ph_q, blink_ph_d;
    logic                 first_q;

    logic [4*DIGITS-1:0]  dv_q;
    logic [7*DIGITS-1:0]  rs_q;
    logic [DIGITS-1:0]    re_q, bl_q, bk_q;

    logic [6:0]           seg_q;
    logic [DIGITS-1:0]    an_q;
    logic                 fs_q;

    logic                 fstart;
    logic [4*DIGITS-1:0]  dv_s;
    logic [7*DIGITS-1:0]  rs_s;
    logic [DIGITS-1:0]    re_s, bl_s, bk_s;
    logic [DIGITS-1:0][6:0] pat;

    // The state registers hold the position of the next output cycle. The
    // frame begins when that position is the first cycle of the leftmost slot.
    // On that edge, live inputs bypass the shadow registers so that the frame
    // shows them from its first cycle.
    always_comb begin
        fstart = (idx_q == IDX_W'(DIGITS - 1)) && (state_q == S_FIRST) && (cnt_q == '0);
        dv_s   = fstart ? digit_val : dv_q;
        rs_s   = fstart ? raw_seg   : rs_q;
        re_s   = fstart ? raw_en    : re_q;
        bl_s   = fstart ? blank     : bl_q;
        bk_s   = fstart ? blink     : bk_q;
    end

    // Frame counter counts completed frames. The first frame after reset
    // does not close a previous frame.
    always_comb begin
        fcnt_d     = fcnt_q;
        blink_ph_d = blink_ph_q;
        if (fstart && !first_q) begin
            if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                fcnt_d     = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg_scan_digit u_dig (
            .nib_i        (dv_s[4*g +: 4]),
            .raw_i        (rs_s[7*g +: 7]),
            .raw_en_i     (re_s[g]),
            .blank_i      (bl_s[g]),
            .blink_i      (bk_s[g]),
            .blink_phase_i(blink_ph_d),
            .pat_o        (pat[g])
        );
    end

    // Scan FSM with registered outputs, shadow capture and blink tracking
    always_ff @(posedge segclk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FIRST;
            idx_q      <= IDX_W'(DIGITS - 1);
            cnt_q      <= '0;
            fcnt_q     <= '0;
            blink_ph_q <= 1'b0;
            first_q    <= 1'b1;
            dv_q       <= '0;
            rs_q       <= '0;
            re_q       <= '0;
            bl_q       <= '0;
            bk_q       <= '0;
            seg_q      <= 7'h7F;
            an_q       <= '1;
            fs_q       <= 1'b0;
        end else begin
            first_q    <= 1'b0;
            fs_q       <= fstart;
            fcnt_q     <= fcnt_d;
            blink_ph_q <= blink_ph_d;
            if (fstart) begin
                dv_q <= digit_val;
                rs_q <= raw_seg;
                re_q <= raw_en;
                bl_q <= blank;
                bk_q <= blink;
            end
            if (state_q == S_DRIVE) begin
                an_q  <= ~(DIGITS'(1) << idx_q);
                seg_q <= pat[idx_q];
            end else begin
                an_q  <= '1;
                seg_q <= 7'h7F;
            end
            case (state_q)
                S_GAP: begin
                    // The gap is at most one cycle long
                    state_q <= S_DRIVE;
                    cnt_q   <= '0;
                end
                default: begin
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_FIRST;
                        idx_q   <= (idx_q == '0) ? IDX_W'(DIGITS - 1) : idx_q - 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux. DUT A uses the 4-digit config with a
// ghost gap. DUT B uses the 8-digit config with no gap.
module tb_seg_scan_mux;
    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dv_a;
    logic [27:0] rs_a;
    logic [3:0]  re_a, bl_a, bk_a;
    logic [6:0]  seg_a;
    logic [3:0]  an_a;
    logic        fs_a;

    logic [31:0] dv_b;
    logic [6:0]  seg_b;
    logic [7:0]  an_b;
    logic        fs_b;

    exp_t qa[$];
    exp_t qb[$];
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .DWELL(2), .GHOST(1), .BLINK_FRAMES(2)) u_a (
        .segclk(clk), .rst(rst), .digit_val(dv_a), .raw_seg(rs_a), .raw_en(re_a),
        .blank(bl_a), .blink(bk_a), .seg(seg_a), .an(an_a), .frame_start(fs_a)
    );

    seg_scan_mux #(.DIGITS(8), .DWELL(1), .GHOST(0), .BLINK_FRAMES(2)) u_b (
        .segclk(clk), .rst(rst), .digit_val(dv_b), .raw_seg(56'h0), .raw_en(8'h0),
        .blank(8'h0), .blink(8'h0), .seg(seg_b), .an(an_b), .frame_start(fs_b)
    );

    // Monitor: compares one scoreboard entry per cycle, 2 ns after the edge
    always @(posedge clk) begin
        exp_t e, g;
        #2;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            g = {4'hF, an_a, seg_a, fs_a};
            nvec++;
            if (g !== e) begin
                nfail++;
                $display("FAIL scanA: got an=%h seg=%h fs=%b, expected an=%h seg=%h fs=%b",
                         g.an, g.seg, g.fs, e.an, e.seg, e.fs);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            g = {an_b, seg_b, fs_b};
            nvec++;
            if (g !== e) begin
                nfail++;
                $display("FAIL scanB: got an=%h seg=%h fs=%b, expected an=%h seg=%h fs=%b",
                         g.an, g.seg, g.fs, e.an, e.seg, e.fs);
            end
        end
        if (rst) begin
            nvec++;
            if ($countones(~an_b) > 1) begin
                nfail++;
                $display("FAIL oneanode: got an=%h, expected at most one low bit", an_b);
            end
        end
    end

    task automatic push_frame_a(input logic [6:0] p3, input logic [6:0] p2,
                                input logic [6:0] p1, input logic [6:0] p0);
        logic [6:0] p[4];
        logic [3:0] at[4];
        p[3] = p3; p[2] = p2; p[1] = p1; p[0] = p0;
        at[3] = 4'h7; at[2] = 4'hB; at[1] = 4'hD; at[0] = 4'hE;
        for (int s = 3; s >= 0; s--) begin
            qa.push_back({8'hFF, 7'h7F, (s == 3)});
            repeat (2) qa.push_back({4'hF, at[s], p[s], 1'b0});
        end
    endtask

    task automatic push_frame_b();
        logic [7:0] ab[8];
        logic [6:0] sb[8];
        ab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        sb = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        for (int k = 0; k < 8; k++) qb.push_back({ab[k], sb[k], (k == 0)});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rst(input string name);
        nvec++;
        if ({an_a, seg_a, fs_a} !== {4'hF, 7'h7F, 1'b0}) begin
            nfail++;
            $display("FAIL %s A: got an=%h seg=%h fs=%b, expected an=f seg=7f fs=0",
                     name, an_a, seg_a, fs_a);
        end
        nvec++;
        if ({an_b, seg_b, fs_b} !== {8'hFF, 7'h7F, 1'b0}) begin
            nfail++;
            $display("FAIL %s B: got an=%h seg=%h fs=%b, expected an=ff seg=7f fs=0",
                     name, an_b, seg_b, fs_b);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() > 0 || qb.size() > 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        nvec++;
        if (qa.size() > 0 || qb.size() > 0) begin
            nfail++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        dv_a = 16'h1234; rs_a = '0; re_a = '0; bl_a = '0; bk_a = '0;
        dv_b = 32'h7654_3210;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk_rst("reset");

        // Release: frames 0..10 with hex scan, mid-frame update, priority, blink
        @(negedge clk);
        rst = 1'b1;
        push_frame_a(7'h79, 7'h24, 7'h30, 7'h19);
        push_frame_a(7'h79, 7'h24, 7'h30, 7'h19);
        push_frame_a(7'h08, 7'h03, 7'h46, 7'h21);
        push_frame_a(7'h08, 7'h7F, 7'h46, 7'h21);
        push_frame_a(7'h08, 7'h3F, 7'h46, 7'h21);
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h00);
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h7F);
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h7F);
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h00);
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h00);
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h7F);
        step(17);                       // cycle 5 of frame 1
        dv_a = 16'hABCD;
        step(13);                       // mid frame 2
        re_a = 4'b0100; rs_a = 28'h3F << 14; bl_a = 4'b0100;
        step(12);                       // mid frame 3
        bl_a = 4'b0000;
        step(12);                       // mid frame 4
        re_a = 4'b0000; bk_a = 4'b0001; dv_a = 16'h0008;
        drain();

        // Reset asserted mid-frame aborts the scan
        rst = 1'b0;
        #1 chk_rst("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        qa.push_back({8'hFF, 7'h7F, 1'b1});
        qa.push_back({8'hF7, 7'h40, 1'b0});
        step(2);                        // middle of first DRIVE cycle
        rst = 1'b0;
        #1 chk_rst("drive_rst");

        // Fresh frame after release, blink phase back to visible
        @(negedge clk);
        rst = 1'b1;
        push_frame_a(7'h40, 7'h40, 7'h40, 7'h00);
        push_frame_b();
        push_frame_b();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 The block SHALL take parameter DIGITS, default 4, as the number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL take parameter DWELL, default 1, as the lit cycles per digit slot (legal >=1).
REQ-003 The block SHALL take parameter GHOST, default 1, as the all-off anti-ghost cycles before each lit phase (legal 0 or 1).
REQ-004 The block SHALL take parameter BLINK_FRAMES, default 32, as the frames per blink half-period (legal >=1).
REQ-005 The block SHALL provide segclk  in  1  scan clock; the block has one clock.
REQ-006 The block SHALL provide rst  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL provide digit_val  in  4*DIGITS  hex nibble per digit; digit i at bits [4i+3:4i]; digit 0 is rightmost.
REQ-008 The block SHALL provide raw_seg  in  7*DIGITS  raw active-low pattern per digit; digit i at bits [7i+6:7i].
REQ-009 The block SHALL provide raw_en  in  DIGITS  per digit, 1 selects raw_seg over the hex decode.
REQ-010 The block SHALL provide blank  in  DIGITS  per digit, 1 forces that digit dark.
REQ-011 The block SHALL provide blink  in  DIGITS  per digit, 1 enables blinking.
REQ-012 The block SHALL provide seg  out  7  active-low segments, bit6=g .. bit0=a, registered.
REQ-013 The block SHALL provide an  out  DIGITS  active-low anodes, registered.
REQ-014 The block SHALL provide frame_start  out  1  one-cycle pulse marking the first output cycle of each frame.

Function
REQ-015 The block SHALL scan digits in the order DIGITS-1 (leftmost) down to 0, then wrap to DIGITS-1.
REQ-016 Each slot SHALL last GHOST+DWELL cycles: first GHOST GAP cycles, then DWELL DRIVE cycles; frame length is DIGITS*(GHOST+DWELL) cycles.
REQ-017 In a GAP cycle, an SHALL be all ones and seg SHALL be 7'h7F.
REQ-018 In a DRIVE cycle, an SHALL have only bit idx low and seg SHALL carry the digit pattern; two anodes SHALL never be low together.
REQ-019 The state machine SHALL have two states: GAP->DRIVE after GHOST cycles; DRIVE->GAP (next idx) after DWELL cycles; with GHOST=0, DRIVE->DRIVE at the next idx.
REQ-020 All inputs SHALL be captured into shadow registers at each frame start; input changes mid-frame SHALL NOT appear until the next frame.
REQ-021 Pattern priority SHALL be: blank[i] -> 7'h7F; else blink[i] and blink_phase=1 -> 7'h7F; else raw_en[i] -> raw_seg[i]; else hex decode.
REQ-022 Hex decode SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit).
REQ-023 A frame counter SHALL count completed frames; when it is BLINK_FRAMES-1 at a frame boundary, it SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-024 frame_start SHALL be 1 exactly in the first output cycle of slot DIGITS-1, and 0 otherwise.
REQ-025 Counter widths SHALL be $clog2 sized, with a minimum of 1 bit; idx SHALL wrap from 0 to DIGITS-1 without overflow.
REQ-026 With DIGITS=1, an SHALL be 1 bit and the single digit SHALL repeat every GHOST+DWELL cycles.

Reset
REQ-027 While rst=0, the outputs SHALL be seg=7'h7F, an=all ones and frame_start=0, applied immediately without waiting for a clock edge.
REQ-028 While rst=0, the internal state SHALL be idx=DIGITS-1, phase counters 0, frame counter 0 and blink_phase=0 (visible).
REQ-029 The first rising edge after rst rises SHALL start frame 0: it captures the shadow registers and produces the first output cycle of slot DIGITS-1, with frame_start=1.
REQ-030 Reset asserted mid-frame SHALL abort the scan, and reset release SHALL restart at a fresh frame with no partial slot.

Verification (DIGITS=4, DWELL=2, GHOST=1, BLINK_FRAMES=2 unless stated)
REQ-031 Test "hex scan": digit_val=16'h1234 with other controls 0 -> per frame, an=F,7,7,F,B,B,F,D,D,F,E,E and seg in DRIVE cycles 79,24,30,19; frame_start every 12 cycles.
REQ-032 Test "mid-frame update": change digit_val to 16'hABCD in cycle 5 of a frame -> the current frame still shows 1234, and the next frame shows 08,03,46,21.
REQ-033 Test "priority": digit 2 with raw_en=1, raw_seg=7'h3F, blank=1 -> seg 7F in digit 2 DRIVE cycles; with blank cleared -> 3F.
REQ-034 Test "blink": blink=4'b0001, digit_val=16'h0008 -> digit 0 shows 00 for 2 frames, then 7F for 2 frames, repeating; other digits are unaffected.
REQ-035 Test "async reset": pull rst low in the middle of a DRIVE cycle -> an=F and seg=7F before the next edge; after release, the first edge gives frame_start=1.
REQ-036 Test "GHOST=0, DWELL=1, DIGITS=8": -> an walks 7F,BF,DF,EF,F7,FB,FD,FE with no gap cycles, and the sweep checks that at most one anode is low in every cycle.
